rc4_sched: RTL and testbench
============================

# rc4_sched

Sequencer for the RC4 S-box RAM (three-port `ram`: read port 1, write port 2, read/write port 3). Runs the identity fill, the 256-round KSA and the PRGA in order, and drives every RAM port. Emits one keystream byte per `cipher_req` cycle. Sits between the cipher top and the `ram` instance, replacing ad-hoc sequencing in the top.

## Interface
Parameters:
- `KEY_MAX`, 16: key storage in bytes, 1..256.

Ports:
- `clk`, input, 1: sole clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `key_setup_en`, input, 1: start pulse; sampled every cycle.
- `key`, input, 8*KEY_MAX: key bytes; byte n at bits [8n+7:8n]; held stable while `busy`.
- `key_len`, input, $clog2(KEY_MAX+1): active key length; 0 is treated as 1.
- `cipher_req`, input, 1: level request for keystream bytes.
- `busy`, output, 1: INIT or KSA in progress.
- `setup_done`, output, 1: KSA complete, PRGA states active.
- `ks_valid`, output, 1: one-cycle pulse, `ks_data` valid.
- `ks_data`, output, 8: keystream byte.
- `raddr_1`, output, 8, and `rdata_1`, input, 8: RAM read port 1.
- `wen_2`, output, 1; `waddr_2`, output, 8; `wdata_2`, output, 8: RAM write port 2.
- `wen_3`, output, 1; `addr_3`, output, 8; `wdata_3`, output, 8; `rdata_3`, input, 8: RAM port 3.

RAM contract:
- Read data appears the cycle after the address.
- Writes occur on the edge where `wen` is high.
- The block never reads and writes the same address in one cycle.

## Operation
State machine states: IDLE, INIT, K_RD, K_J, K_RJ, K_SW, P_WAIT, P_RI, P_J, P_RJ, P_SW, P_RT, P_OUT.

- **Reset:**
  - All outputs are 0; `wen_2` and `wen_3` are low.
  - Counters `i`, `j` and `kidx` are 0; state is IDLE.
- **IDLE:** `key_setup_en` → INIT with `i`=0.
- **INIT:**
  - Per cycle: `wen_2`=1, `waddr_2`=`i`, `wdata_2`=`i`, then `i`++.
  - After `i`=255 is written → K_RD with `i`=0, `j`=0, `kidx`=0.
- **KSA** (4 cycles per round):
  - K_RD: `raddr_1`=`i`.
  - K_J: latch `Si`=`rdata_1`; `j` ← `j` + `rdata_1` + `key[kidx]` (mod 256); `kidx` ← (`kidx`+1 == `key_len`) ? 0 : `kidx`+1.
  - K_RJ: `addr_3`=`j`.
  - K_SW: write S[i]←`rdata_3` via port 2 and S[j]←`Si` via port 3. `wen_3` is suppressed when `i`==`j`. Then `i`++.
  - After the swap with `i`=255 → P_WAIT with `i`=0, `j`=0, `setup_done`=1.
- **PRGA:**
  - P_WAIT: wait for `cipher_req`, then go to P_RI.
  - P_RI: `i`++; `raddr_1`=new `i`.
  - P_J: latch `Si`; `j` ← `j`+`rdata_1`.
  - P_RJ: `addr_3`=`j`.
  - P_SW: swap as in K_SW; latch `Sj`=`rdata_3`.
  - P_RT: `raddr_1`=`Si`+`Sj` (mod 256).
  - P_OUT: `ks_data`=`rdata_1` (registered), `ks_valid`=1. Go to P_RI if `cipher_req` is still high, else P_WAIT.
- `ks_data` holds its last value between pulses.
- `key_setup_en` in any non-IDLE state aborts and restarts INIT:
  - `setup_done` clears.
  - Any pending `ks_valid` is dropped.
  - Writes issued before the abort edge stand.
- `cipher_req` outside the PRGA states is ignored. There is no backpressure: a byte is lost if the consumer is not ready.

## Timing
- INIT: 256 cycles.
- KSA: 1024 cycles.
- `setup_done` rises 1280 edges after the edge that samples `key_setup_en`.
- `busy` is high for exactly those 1280 cycles.
- Keystream: first `ks_valid` comes 6 cycles after `cipher_req` is sampled in P_WAIT. Sustained rate is one byte per 6 cycles.
- `i` and `j` wrap modulo 256; the `i`=255→0 wrap in PRGA is normal.
- Asynchronous reset mid-KSA or mid-PRGA returns the block to IDLE immediately. RAM contents are undefined afterwards; a new `key_setup_en` is required.

## Structure
- `rc4_pkg` holds:
  - the state enum;
  - `SBOX_DEPTH`=256;
  - `ADDR_W`=8;
  - the KSA/PRGA cycle-count constants, shared with the bench.
- One sub-module, `rc4_key_sel`: combinational byte mux `key[kidx]` over `KEY_MAX` bytes.
- The RAM is instantiated by the parent top, not inside this block.

## Test plan
- Key "Key", `key_len`=3, `cipher_req` held high → `ks_data` = EB 9F 77 81 B7, with pulses 6 cycles apart.
- Key "Wiki", `key_len`=4 → 60 44 DB 6D 41. Key "Secret", `key_len`=6 → 04 D4 6B 05 3C.
- Count from the `key_setup_en` edge → `busy` high for 1280 cycles. RAM model holds S[n]=n after the 256th cycle. No same-address read/write collisions occur.
- Pulse `key_setup_en` mid-KSA (cycle 700), then key "Key" → output identical to a clean run.
- `cipher_req` pulsed for one cycle only → exactly one `ks_valid`, then P_WAIT. 300 bytes requested → `i` wraps correctly, matching the reference model.
- Assert `rst_n` low mid-PRGA → outputs are 0 immediately. A new setup with "Wiki" → correct vector.

Source files
------------

// File: rtl/rc4_pkg.sv
// Shared types and constants for the RC4 S-box sequencer.
// The cycle-count constants are also used by the bench to check timing.
package rc4_pkg;

  localparam int SBOX_DEPTH       = 256;
  localparam int ADDR_W           = 8;
  localparam int INIT_CYCLES      = SBOX_DEPTH;
  localparam int KSA_ROUND_CYCLES = 4;
  localparam int KSA_CYCLES       = SBOX_DEPTH * KSA_ROUND_CYCLES;
  localparam int SETUP_CYCLES     = INIT_CYCLES + KSA_CYCLES;
  localparam int PRGA_CYCLES      = 6;
  localparam int PRGA_FIRST_LAT   = 6;

  typedef enum logic [3:0] {
    IDLE, INIT,
    K_RD, K_J, K_RJ, K_SW,
    P_WAIT, P_RI, P_J, P_RJ, P_SW, P_RT, P_OUT
  } rc4_state_e;

  // Address guaranteed to differ from both a and b; parks idle read ports
  // away from any address being written this cycle.
  function automatic logic [ADDR_W-1:0] free_addr(input logic [ADDR_W-1:0] a,
                                                  input logic [ADDR_W-1:0] b);
    logic [ADDR_W-1:0] c;
    c = a ^ ADDR_W'(1);
    return (c == b) ? (a ^ ADDR_W'(2)) : c;
  endfunction

endpackage

// File: rtl/rc4_sched_if.sv
// Port bundle between the RC4 sequencer (master) and the three-port S-box RAM (slave).
interface rc4_sched_if;
  import rc4_pkg::*;

  logic [ADDR_W-1:0] raddr_1;
  logic [7:0]        rdata_1;
  logic              wen_2;
  logic [ADDR_W-1:0] waddr_2;
  logic [7:0]        wdata_2;
  logic              wen_3;
  logic [ADDR_W-1:0] addr_3;
  logic [7:0]        wdata_3;
  logic [7:0]        rdata_3;

  modport master (
    output raddr_1, wen_2, waddr_2, wdata_2, wen_3, addr_3, wdata_3,
    input  rdata_1, rdata_3
  );

  modport slave (
    input  raddr_1, wen_2, waddr_2, wdata_2, wen_3, addr_3, wdata_3,
    output rdata_1, rdata_3
  );

endinterface

// File: rtl/rc4_key_sel.sv
// Combinational key-byte mux: selects key[idx] out of KEY_MAX bytes (AND-OR tree).
module rc4_key_sel #(
  parameter int KEY_MAX = 16
) (
  input  logic [KEY_MAX-1:0][7:0]          key,
  input  logic [$clog2(KEY_MAX+1)-1:0]     idx,
  output logic [7:0]                       kbyte
);

  logic [KEY_MAX-1:0][7:0] masked;

  for (genvar n = 0; n < KEY_MAX; n++) begin : g_byte
    assign masked[n] = (idx == ($clog2(KEY_MAX+1))'(n)) ? key[n] : 8'h00;
  end

  always_comb begin
    kbyte = 8'h00;
    for (int n = 0; n < KEY_MAX; n++) kbyte = kbyte | masked[n];
  end

endmodule

// File: rtl/rc4_sched.sv
// RC4 S-box sequencer: identity fill, 256-round KSA, then PRGA emitting one
// keystream byte per 6-cycle round while cipher_req is high.
module rc4_sched
  import rc4_pkg::*;
#(
  parameter int KEY_MAX = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         key_setup_en,
  input  logic [8*KEY_MAX-1:0]         key,
  input  logic [$clog2(KEY_MAX+1)-1:0] key_len,
  input  logic                         cipher_req,
  output logic                         busy,
  output logic                         setup_done,
  output logic                         ks_valid,
  output logic [7:0]                   ks_data,
  rc4_sched_if.master                  ram
);

  localparam int KL_W = $clog2(KEY_MAX+1);

  rc4_state_e        state_q, state_d;
  logic [ADDR_W-1:0] i_q, j_q;
  logic [7:0]        si_q, sj_q;
  logic [KL_W-1:0]   kidx_q, kidx_inc, klen;
  logic [7:0]        kbyte;

  rc4_key_sel #(.KEY_MAX(KEY_MAX)) u_key_sel (
    .key   (key),
    .idx   (kidx_q),
    .kbyte (kbyte)
  );

  assign klen       = (key_len == '0) ? KL_W'(1) : key_len;
  assign kidx_inc   = kidx_q + KL_W'(1);
  assign busy       = state_q inside {INIT, K_RD, K_J, K_RJ, K_SW};
  assign setup_done = state_q inside {P_WAIT, P_RI, P_J, P_RJ, P_SW, P_RT, P_OUT};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ram.raddr_1 = '0;
    ram.wen_2   = 1'b0;
    ram.waddr_2 = '0;
    ram.wdata_2 = '0;
    ram.wen_3   = 1'b0;
    ram.addr_3  = '0;
    ram.wdata_3 = '0;
    unique case (state_q)
      IDLE: ;
      INIT: begin
        ram.wen_2   = 1'b1;
        ram.waddr_2 = i_q;
        ram.wdata_2 = i_q;
        ram.raddr_1 = free_addr(i_q, i_q);
        ram.addr_3  = free_addr(i_q, i_q);
        if (i_q == 8'hFF) state_d = K_RD;
      end
      K_RD: begin
        ram.raddr_1 = i_q;
        state_d     = K_J;
      end
      K_J:  state_d = K_RJ;
      K_RJ: begin
        ram.addr_3 = j_q;
        state_d    = K_SW;
      end
      K_SW, P_SW: begin
        // When i==j port 3 stays a read, so steer it off the address port 2 writes.
        ram.wen_2   = 1'b1;
        ram.waddr_2 = i_q;
        ram.wdata_2 = ram.rdata_3;
        ram.wen_3   = (i_q != j_q);
        ram.addr_3  = (i_q != j_q) ? j_q : free_addr(i_q, i_q);
        ram.wdata_3 = si_q;
        ram.raddr_1 = free_addr(i_q, j_q);
        if (state_q == P_SW)    state_d = P_RT;
        else if (i_q == 8'hFF)  state_d = P_WAIT;
        else                    state_d = K_RD;
      end
      P_WAIT: if (cipher_req) state_d = P_RI;
      P_RI: begin
        ram.raddr_1 = i_q + 8'd1;
        state_d     = P_J;
      end
      P_J:  state_d = P_RJ;
      P_RJ: begin
        ram.addr_3 = j_q;
        state_d    = P_SW;
      end
      P_RT: begin
        ram.raddr_1 = si_q + sj_q;
        state_d     = P_OUT;
      end
      P_OUT:   state_d = cipher_req ? P_RI : P_WAIT;
      default: state_d = IDLE;
    endcase
    if (key_setup_en) state_d = INIT;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q      <= '0;
      j_q      <= '0;
      kidx_q   <= '0;
      si_q     <= '0;
      sj_q     <= '0;
      ks_valid <= 1'b0;
      ks_data  <= '0;
    end else begin
      ks_valid <= 1'b0;
      if (key_setup_en) begin
        i_q <= '0;
      end else begin
        unique case (state_q)
          INIT: begin
            i_q <= i_q + 8'd1;
            if (i_q == 8'hFF) begin
              j_q    <= '0;
              kidx_q <= '0;
            end
          end
          K_J: begin
            si_q   <= ram.rdata_1;
            j_q    <= j_q + ram.rdata_1 + kbyte;
            kidx_q <= (kidx_inc == klen) ? '0 : kidx_inc;
          end
          K_SW: begin
            i_q <= i_q + 8'd1;
            if (i_q == 8'hFF) j_q <= '0;
          end
          P_RI: i_q <= i_q + 8'd1;
          P_J: begin
            si_q <= ram.rdata_1;
            j_q  <= j_q + ram.rdata_1;
          end
          P_SW: sj_q <= ram.rdata_3;
          P_OUT: begin
            ks_valid <= 1'b1;
            ks_data  <= ram.rdata_1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rc4_sched.sv
// Bench for rc4_sched: behavioral three-port RAM, known-answer keystream table,
// and directed sequences for abort, single request, wrap and async reset.
module tb_rc4_sched;
  import rc4_pkg::*;

  localparam int KEY_MAX = 16;
  localparam int KL_W    = $clog2(KEY_MAX+1);

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 key_setup_en = 1'b0;
  logic                 cipher_req = 1'b0;
  logic [8*KEY_MAX-1:0] key = '0;
  logic [KL_W-1:0]      key_len = '0;
  logic                 busy, setup_done, ks_valid;
  logic [7:0]           ks_data;

  rc4_sched_if ram_if ();

  rc4_sched #(.KEY_MAX(KEY_MAX)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_setup_en (key_setup_en),
    .key          (key),
    .key_len      (key_len),
    .cipher_req   (cipher_req),
    .busy         (busy),
    .setup_done   (setup_done),
    .ks_valid     (ks_valid),
    .ks_data      (ks_data),
    .ram          (ram_if)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_if.wen_2) mem[ram_if.waddr_2] <= ram_if.wdata_2;
    if (ram_if.wen_3) mem[ram_if.addr_3]  <= ram_if.wdata_3;
    ram_if.rdata_1 <= mem[ram_if.raddr_1];
    ram_if.rdata_3 <= mem[ram_if.addr_3];
  end

  int         n_cmp = 0, n_fail = 0;
  int         cyc = 0, viol = 0, t0 = 0;
  logic [7:0] ks_q [$];
  int         ks_t [$];
  logic [7:0] ref_ks [0:511];

  always @(negedge clk) begin
    cyc++;
    if (ks_valid) begin
      ks_q.push_back(ks_data);
      ks_t.push_back(cyc);
    end
    if (ram_if.wen_2 && (ram_if.raddr_1 == ram_if.waddr_2 || ram_if.addr_3 == ram_if.waddr_2)) viol++;
    if (ram_if.wen_3 && ram_if.raddr_1 == ram_if.addr_3) viol++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8*KEY_MAX-1:0] pack_key(input string s);
    logic [8*KEY_MAX-1:0] k;
    k = '0;
    for (int n = 0; n < s.len(); n++) k[8*n +: 8] = s[n];
    return k;
  endfunction

  // Textbook RC4 reference, 512 keystream bytes.
  task automatic compute_ref(input string s);
    logic [7:0] sb [0:255];
    logic [7:0] t, ii, jj;
    int len;
    len = s.len();
    for (int n = 0; n < 256; n++) sb[n] = 8'(n);
    jj = 0;
    for (int n = 0; n < 256; n++) begin
      jj = jj + sb[n] + 8'(s[n % len]);
      t = sb[n]; sb[n] = sb[jj]; sb[jj] = t;
    end
    ii = 0; jj = 0;
    for (int n = 0; n < 512; n++) begin
      ii = ii + 8'd1;
      jj = jj + sb[ii];
      t = sb[ii]; sb[ii] = sb[jj]; sb[jj] = t;
      ref_ks[n] = sb[8'(sb[ii] + sb[jj])];
    end
  endtask

  task automatic pulse_setup(input string s);
    key          = pack_key(s);
    key_len      = KL_W'(s.len());
    key_setup_en = 1'b1;
    tick();
    key_setup_en = 1'b0;
  endtask

  task automatic setup(input string s, input bit chk_fill);
    int cnt, bad;
    cnt = 0;
    pulse_setup(s);
    while (busy && cnt < 2000) begin
      if (chk_fill && cnt == INIT_CYCLES) begin
        bad = 0;
        for (int n = 0; n < 256; n++) if (mem[n] !== 8'(n)) bad++;
        chk("init fill bad entries", bad, 0);
      end
      cnt++;
      tick();
    end
    chk($sformatf("%s busy cycles", s), cnt, SETUP_CYCLES);
    chk($sformatf("%s setup_done", s), setup_done, 1);
  endtask

  task automatic start_stream();
    ks_q.delete();
    ks_t.delete();
    t0 = cyc;
    cipher_req = 1'b1;
  endtask

  task automatic wait_bytes(input int n);
    int b;
    b = 0;
    while (ks_q.size() < n && b < 8*n + 40) begin
      tick();
      b++;
    end
    cipher_req = 1'b0;
    repeat (12) tick();
  endtask

  task automatic check5(input string tag, input logic [39:0] exp);
    logic [7:0] g;
    int bad_gap;
    bad_gap = 0;
    for (int m = 0; m < 5; m++) begin
      g = 'x;
      if (m < ks_q.size()) g = ks_q[m];
      chk($sformatf("%s byte%0d", tag, m), g, exp[39-8*m -: 8]);
    end
    // Request is driven half a cycle before its sampling edge and valid is
    // seen half a cycle after its edge, hence the +1.
    chk($sformatf("%s first latency", tag), (ks_t.size() > 0) ? ks_t[0] - t0 : -1,
        PRGA_FIRST_LAT + 1);
    for (int m = 1; m < 5 && m < ks_t.size(); m++)
      if (ks_t[m] - ks_t[m-1] != PRGA_CYCLES) bad_gap++;
    chk($sformatf("%s pulse spacing errors", tag), bad_gap, 0);
  endtask

  typedef struct {
    string       k;
    logic [39:0] exp;
  } vec_t;

  vec_t vt [3];

  initial begin
    int pos, bad;
    vt[0].k = "Key";    vt[0].exp = 40'hEB9F7781B7;
    vt[1].k = "Wiki";   vt[1].exp = 40'h6044DB6D41;
    vt[2].k = "Secret"; vt[2].exp = 40'h04D46B053C;

    repeat (3) tick();
    chk("reset ctl outputs", {busy, setup_done, ks_valid, ks_data, ram_if.wen_2, ram_if.wen_3}, 0);
    chk("reset ram bus", {ram_if.raddr_1, ram_if.waddr_2, ram_if.wdata_2, ram_if.addr_3, ram_if.wdata_3}, 0);
    rst_n = 1'b1;
    tick();
    cipher_req = 1'b1;
    repeat (10) tick();
    chk("req ignored in idle", {ks_valid, busy, setup_done}, 0);
    cipher_req = 1'b0;

    for (int v = 0; v < 3; v++) begin
      setup(vt[v].k, v == 0);
      start_stream();
      wait_bytes(5);
      check5(vt[v].k, vt[v].exp);
    end

    // Abort mid-KSA with a different key, then restart with "Key".
    pulse_setup("Secret");
    repeat (699) tick();
    chk("busy before abort", busy, 1);
    setup("Key", 1'b0);
    compute_ref("Key");
    start_stream();
    wait_bytes(5);
    check5("abort Key", vt[0].exp);

    // One-cycle request: exactly one byte, continuing the stream.
    pos = ks_q.size();
    cipher_req = 1'b1;
    tick();
    cipher_req = 1'b0;
    repeat (30) tick();
    chk("single req pulse count", ks_q.size() - pos, 1);
    chk("single req byte", (ks_q.size() > pos) ? ks_q[pos] : 8'hxx, ref_ks[pos]);
    chk("single req back to wait", {setup_done, busy}, 2'b10);

    // 300 bytes: i wraps past 255.
    pos = ks_q.size();
    cipher_req = 1'b1;
    wait_bytes(pos + 300);
    chk("300 byte count", ks_q.size() >= pos + 300, 1);
    bad = 0;
    for (int m = 0; m < 300; m++)
      if (pos + m >= ks_q.size() || ks_q[pos+m] !== ref_ks[pos+m]) bad++;
    chk("300 byte stream errors", bad, 0);

    // Async reset mid-PRGA.
    cipher_req = 1'b1;
    repeat (20) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async rst outputs", {busy, setup_done, ks_valid, ks_data, ram_if.wen_2, ram_if.wen_3}, 0);
    cipher_req = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    setup("Wiki", 1'b0);
    start_stream();
    wait_bytes(5);
    check5("post-reset Wiki", vt[1].exp);

    chk("ram collisions", viol, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
